// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: register map, CTRL/STAT bit positions and per-channel state
// for the timer_bank block. Channel state is sized for the widest supported
// counter (32 bits); narrower builds keep the upper bits at zero.
package timer_bank_pkg;

  // Register byte offsets inside one channel window
  localparam logic [3:0] OFF_CTRL = 4'd0;
  localparam logic [3:0] OFF_STAT = 4'd1;
  localparam logic [3:0] OFF_RLD0 = 4'd4;
  localparam logic [3:0] OFF_RLD1 = 4'd5;
  localparam logic [3:0] OFF_RLD2 = 4'd6;
  localparam logic [3:0] OFF_RLD3 = 4'd7;
  localparam logic [3:0] OFF_CNT0 = 4'd8;
  localparam logic [3:0] OFF_CNT1 = 4'd9;
  localparam logic [3:0] OFF_CNT2 = 4'd10;
  localparam logic [3:0] OFF_CNT3 = 4'd11;

  // CTRL bit indices (LOAD is a write-only strobe, never stored)
  localparam int CTRL_EN       = 0;
  localparam int CTRL_DOWN     = 1;
  localparam int CTRL_PERIODIC = 2;
  localparam int CTRL_IE       = 3;
  localparam int CTRL_LOAD     = 4;

  // STAT bit indices
  localparam int STAT_EXP = 0;
  localparam int STAT_EN  = 1;

  // Per-channel state
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] reload;
    logic [31:0] count;
    logic [31:0] shadow;
    logic        exp;
  } TimerCh;

  // Mask selecting the low w bits of a 32-bit value
  function automatic logic [31:0] ctr_mask(input int w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << w) - 32'd1;
    end
  endfunction

  // Byte k (0 = LSB) of a 32-bit value
  function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] k);
    case (k)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      2'd2:    return v[23:16];
      2'd3:    return v[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/timer_bank_tick_gen.sv
// tick_gen: shared tick divider. The counter runs 0..DIV-1 and tick is high
// for exactly the cycle in which the counter holds DIV-1. tick is a flop
// that is pre-set one cycle early so it stays glitch-free.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] div_r;

  // Divider counter, wraps after DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (div_r == W'(DIV - 1)) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + W'(1);
    end
  end

  // Tick flag: set when the divider is about to reach DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
    end else begin
      tick <= (div_r == W'(DIV - 2));
    end
  end

endmodule

// File: rtl/timer_bank.sv
// timer_bank: CH_NUM independent CTR_W-bit up/down timers sharing one tick,
// with per-channel reload, atomic multi-byte count reads and an optional
// expiry interrupt. Build option: define TIMER_BANK_IRQ_EN to implement the
// EXP flags, the IE bit and irq; without it those read 0 and irq is tied low.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int CH_NUM  = 4,
  parameter int CTR_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [6:0] addr,
  input  logic [7:0] dati,
  input  logic       we,
  input  logic       oe,
  output logic [7:0] dato,
  output logic       tick_o,
  output logic       irq
);

  localparam int          DIV      = CLK_HZ / TICK_HZ;
  localparam int          NBYTES   = CTR_W / 8;
  localparam logic [31:0] MASK     = ctr_mask(CTR_W);
  localparam logic [3:0]  CH_NUM_L = 4'(CH_NUM);
  localparam logic [3:0]  STAT_HI  = 4'(CH_NUM - 1);

`ifdef TIMER_BANK_IRQ_EN
  localparam logic HAS_IRQ = 1'b1;
`else
  localparam logic HAS_IRQ = 1'b0;
`endif

  logic       tick_s;
  logic [2:0] ch_idx_s;
  logic [3:0] off_s;
  logic       wr_s;
  logic       rd_s;
  TimerCh     ch_s [8];
  TimerCh     cs_s;
  logic [7:0] rd_data_s;

  assign ch_idx_s = addr[6:4];
  assign off_s    = addr[3:0];
  assign wr_s     = we & ce;
  assign rd_s     = oe & ce;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  assign tick_o = tick_s;

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < CH_NUM) begin : g_on
      TimerCh st_r;
      TimerCh nxt_s;
      logic   sel_s;
      logic   exp_set_s;

      assign sel_s     = (ch_idx_s == 3'(i));
      // Expiry uses the pre-write CTRL so a same-edge CTRL write acts afterwards
      assign exp_set_s = tick_s & st_r.ctrl[CTRL_EN] & st_r.ctrl[CTRL_DOWN]
                         & (st_r.count == 32'd0);

      // Next-state: tick first, then bus writes (LOAD overrides the tick)
      always_comb begin
        nxt_s = st_r;
        if (tick_s && st_r.ctrl[CTRL_EN]) begin
          if (!st_r.ctrl[CTRL_DOWN]) begin
            nxt_s.count = (st_r.count + 32'd1) & MASK;
          end else if (st_r.count != 32'd0) begin
            nxt_s.count = st_r.count - 32'd1;
          end else begin
            nxt_s.exp = HAS_IRQ;
            if (st_r.ctrl[CTRL_PERIODIC]) begin
              nxt_s.count = st_r.reload;
            end else begin
              nxt_s.ctrl[CTRL_EN] = 1'b0;
            end
          end
        end else begin
          nxt_s.count = st_r.count;
        end

        if (wr_s && sel_s) begin
          case (off_s)
            OFF_CTRL: begin
              nxt_s.ctrl = {dati[CTRL_IE] & HAS_IRQ, dati[2:0]};
              if (dati[CTRL_LOAD]) begin
                nxt_s.count = st_r.reload;
              end else begin
                nxt_s.count = nxt_s.count;
              end
            end
            // Clearing EXP never beats a same-edge expiry
            OFF_STAT: nxt_s.exp = (st_r.exp & ~dati[STAT_EXP]) | (exp_set_s & HAS_IRQ);
            OFF_RLD0: nxt_s.reload[7:0] = dati;
            OFF_RLD1: begin
              if (NBYTES > 1) begin
                nxt_s.reload[15:8] = dati;
              end else begin
                nxt_s.reload = st_r.reload;
              end
            end
            OFF_RLD2: begin
              if (NBYTES > 2) begin
                nxt_s.reload[23:16] = dati;
              end else begin
                nxt_s.reload = st_r.reload;
              end
            end
            OFF_RLD3: begin
              if (NBYTES > 3) begin
                nxt_s.reload[31:24] = dati;
              end else begin
                nxt_s.reload = st_r.reload;
              end
            end
            default: nxt_s.reload = st_r.reload;
          endcase
        end else begin
          nxt_s.reload = st_r.reload;
        end

        // Reading count byte 0 snapshots the whole live count
        if (rd_s && sel_s && (off_s == OFF_CNT0)) begin
          nxt_s.shadow = st_r.count;
        end else begin
          nxt_s.shadow = st_r.shadow;
        end
      end

      // Channel state register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_r <= '0;
        end else begin
          st_r <= nxt_s;
        end
      end

      assign ch_s[i] = st_r;
    end else begin : g_off
      assign ch_s[i] = '0;
    end
  end

`ifdef TIMER_BANK_IRQ_EN
  logic [7:0] exp_irq_s;

  // Per-channel enabled expiry flags
  always_comb begin
    exp_irq_s = 8'h00;
    for (int k = 0; k < 8; k++) begin
      exp_irq_s[k] = ch_s[k].exp & ch_s[k].ctrl[CTRL_IE];
    end
  end

  assign irq = |exp_irq_s;
`else
  assign irq = 1'b0;
`endif

  // Read data mux for the addressed channel/register
  always_comb begin
    cs_s      = ch_s[ch_idx_s];
    rd_data_s = 8'hFF;
    if ({1'b0, ch_idx_s} >= CH_NUM_L) begin
      rd_data_s = 8'hFF;
    end else begin
      case (off_s)
        OFF_CTRL: rd_data_s = {4'h0, cs_s.ctrl};
        OFF_STAT: rd_data_s = {STAT_HI, 2'b00, cs_s.ctrl[CTRL_EN], cs_s.exp};
        OFF_RLD0: rd_data_s = byte_sel(cs_s.reload, 2'd0);
        OFF_RLD1: rd_data_s = byte_sel(cs_s.reload, 2'd1);
        OFF_RLD2: rd_data_s = byte_sel(cs_s.reload, 2'd2);
        OFF_RLD3: rd_data_s = byte_sel(cs_s.reload, 2'd3);
        OFF_CNT0: rd_data_s = byte_sel(cs_s.count, 2'd0);
        OFF_CNT1: rd_data_s = byte_sel(cs_s.shadow, 2'd1);
        OFF_CNT2: rd_data_s = byte_sel(cs_s.shadow, 2'd2);
        OFF_CNT3: rd_data_s = byte_sel(cs_s.shadow, 2'd3);
        default:  rd_data_s = 8'hFF;
      endcase
    end
  end

  // Registered read data, held until the next read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dato <= 8'h00;
    end else if (rd_s) begin
      dato <= rd_data_s;
    end else begin
      dato <= dato;
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: table-driven register checks plus hand-written sequences for
// tick timing, periodic/one-shot down counting, atomic reads and same-edge
// event ordering. Expectations follow the TIMER_BANK_IRQ_EN build option.
module tb_timer_bank;

`ifdef TIMER_BANK_IRQ_EN
  localparam logic       IRQ_EXP = 1'b1;
  localparam logic [7:0] EXP_B   = 8'h01;
  localparam logic [7:0] IE_B    = 8'h08;
`else
  localparam logic       IRQ_EXP = 1'b0;
  localparam logic [7:0] EXP_B   = 8'h00;
  localparam logic [7:0] IE_B    = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [6:0] addr;
  logic [7:0] dati;
  logic       we;
  logic       oe;
  logic [7:0] dato;
  logic       tick_o;
  logic       irq;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  int edge_cnt;
  int n_seen = 0;
  int tick_at [3];

  typedef struct {
    logic       wr;
    logic [2:0] ch;
    logic [3:0] off;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [24];

  timer_bank #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .CH_NUM  (4),
    .CTR_W   (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .addr   (addr),
    .dati   (dati),
    .we     (we),
    .oe     (oe),
    .dato   (dato),
    .tick_o (tick_o),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Record the edge counts at which the first three ticks are visible
  always @(negedge clk) begin
    if (rst_n && tick_o && n_seen < 3) begin
      tick_at[n_seen] <= edge_cnt;
      n_seen          <= n_seen + 1;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  task automatic wr(input logic [2:0] ch, input logic [3:0] off, input logic [7:0] d);
    addr = {ch, off}; dati = d; ce = 1'b1; we = 1'b1;
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] ch, input logic [3:0] off, output logic [7:0] v);
    addr = {ch, off}; ce = 1'b1; oe = 1'b1;
    @(negedge clk);
    ce = 1'b0; oe = 1'b0;
    v = dato;
  endtask

  // Return at the negedge just before a tick edge (bounded wait)
  task automatic sync_tick();
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (tick_o) return;
    end
    chk_cnt++;
    $display("FAIL sync_tick: no tick within 25 cycles, got 0, expected 1");
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; oe = 1'b0; addr = 7'd0; dati = 8'd0;

    tbl[0]  = '{1'b0, 3'd0, 4'd0,  8'h00, 8'h00};
    tbl[1]  = '{1'b0, 3'd0, 4'd1,  8'h00, 8'h30};
    tbl[2]  = '{1'b0, 3'd0, 4'd4,  8'h00, 8'h00};
    tbl[3]  = '{1'b0, 3'd0, 4'd8,  8'h00, 8'h00};
    tbl[4]  = '{1'b0, 3'd0, 4'd2,  8'h00, 8'hFF};
    tbl[5]  = '{1'b0, 3'd0, 4'd12, 8'h00, 8'hFF};
    tbl[6]  = '{1'b0, 3'd0, 4'd15, 8'h00, 8'hFF};
    tbl[7]  = '{1'b1, 3'd3, 4'd4,  8'hA5, 8'h00};
    tbl[8]  = '{1'b1, 3'd3, 4'd5,  8'h5A, 8'h00};
    tbl[9]  = '{1'b1, 3'd3, 4'd6,  8'h77, 8'h00};
    tbl[10] = '{1'b0, 3'd3, 4'd4,  8'h00, 8'hA5};
    tbl[11] = '{1'b0, 3'd3, 4'd5,  8'h00, 8'h5A};
    tbl[12] = '{1'b0, 3'd3, 4'd6,  8'h00, 8'h00};
    tbl[13] = '{1'b0, 3'd3, 4'd7,  8'h00, 8'h00};
    tbl[14] = '{1'b1, 3'd3, 4'd0,  8'h0C, 8'h00};
    tbl[15] = '{1'b0, 3'd3, 4'd0,  8'h00, 8'h04 | IE_B};
    tbl[16] = '{1'b1, 3'd3, 4'd0,  8'h00, 8'h00};
    tbl[17] = '{1'b0, 3'd3, 4'd0,  8'h00, 8'h00};
    tbl[18] = '{1'b0, 3'd5, 4'd0,  8'h00, 8'hFF};
    tbl[19] = '{1'b1, 3'd5, 4'd4,  8'h11, 8'h00};
    tbl[20] = '{1'b0, 3'd5, 4'd4,  8'h00, 8'hFF};
    tbl[21] = '{1'b0, 3'd1, 4'd4,  8'h00, 8'h00};
    tbl[22] = '{1'b0, 3'd7, 4'd1,  8'h00, 8'hFF};
    tbl[23] = '{1'b0, 3'd3, 4'd1,  8'h00, 8'h30};

    repeat (2) @(negedge clk);
    chk("rst_dato", dato, 8'h00);
    chk("rst_tick", {7'd0, tick_o}, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;

    // Idle: ticks visible after edges 9, 19, 29
    repeat (35) @(negedge clk);
    chk("tick_1", 8'(tick_at[0]), 8'd9);
    chk("tick_2", 8'(tick_at[1]), 8'd19);
    chk("tick_3", 8'(tick_at[2]), 8'd29);
    rd(3'd0, 4'd8, v); chk("idle_cnt0", v, 8'h00);
    rd(3'd0, 4'd9, v); chk("idle_cnt1", v, 8'h00);
    chk("idle_irq", {7'd0, irq}, 8'h00);

    // Register access table
    for (int i = 0; i < 24; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].ch, tbl[i].off, tbl[i].data);
      end else begin
        rd(tbl[i].ch, tbl[i].off, v);
        chk($sformatf("tbl[%0d]", i), v, tbl[i].exp);
      end
    end

    // Ch1 periodic down count 3,2,1,0 then reload
    sync_tick(); @(negedge clk);
    wr(3'd1, 4'd4, 8'h03);
    wr(3'd1, 4'd0, 8'h1F);
    rd(3'd1, 4'd8, v); chk("ch1_cnt3", v, 8'h03);
    sync_tick(); @(negedge clk); rd(3'd1, 4'd8, v); chk("ch1_cnt2", v, 8'h02);
    sync_tick(); @(negedge clk); rd(3'd1, 4'd8, v); chk("ch1_cnt1", v, 8'h01);
    sync_tick(); @(negedge clk); rd(3'd1, 4'd8, v); chk("ch1_cnt0", v, 8'h00);
    chk("ch1_irq_pre", {7'd0, irq}, 8'h00);
    sync_tick(); @(negedge clk);
    chk("ch1_irq_exp", {7'd0, irq}, {7'd0, IRQ_EXP});
    rd(3'd1, 4'd8, v); chk("ch1_reload", v, 8'h03);
    rd(3'd1, 4'd1, v); chk("ch1_stat", v, 8'h32 | EXP_B);
    wr(3'd1, 4'd1, 8'h01);
    chk("ch1_irq_clr", {7'd0, irq}, 8'h00);
    rd(3'd1, 4'd1, v); chk("ch1_stat_clr", v, 8'h32);
    wr(3'd1, 4'd0, 8'h00);

    // Ch2 one-shot from 2
    sync_tick(); @(negedge clk);
    wr(3'd2, 4'd4, 8'h02);
    wr(3'd2, 4'd0, 8'h1B);
    repeat (3) begin sync_tick(); @(negedge clk); end
    rd(3'd2, 4'd8, v); chk("ch2_cnt", v, 8'h00);
    rd(3'd2, 4'd1, v); chk("ch2_stat", v, 8'h30 | EXP_B);
    chk("ch2_irq", {7'd0, irq}, {7'd0, IRQ_EXP});
    repeat (5) begin sync_tick(); @(negedge clk); end
    rd(3'd2, 4'd8, v); chk("ch2_hold", v, 8'h00);
    rd(3'd2, 4'd0, v); chk("ch2_ctrl", v, 8'h02 | IE_B);
    wr(3'd2, 4'd1, 8'h01);
    chk("ch2_irq_clr", {7'd0, irq}, 8'h00);

    // Ch0 up mode atomic read across a carry
    sync_tick(); @(negedge clk);
    wr(3'd0, 4'd4, 8'hFF);
    wr(3'd0, 4'd5, 8'h00);
    wr(3'd0, 4'd0, 8'h11);
    rd(3'd0, 4'd8, v); chk("ch0_b0", v, 8'hFF);
    sync_tick(); @(negedge clk);
    rd(3'd0, 4'd9, v); chk("ch0_b1_shadow", v, 8'h00);
    rd(3'd0, 4'd8, v); chk("ch0_b0_live", v, 8'h00);
    rd(3'd0, 4'd9, v); chk("ch0_b1_new", v, 8'h01);

    // Ch0 EN write on a tick edge: tick sees old EN=0
    wr(3'd0, 4'd0, 8'h10);
    sync_tick();
    wr(3'd0, 4'd0, 8'h01);
    rd(3'd0, 4'd8, v); chk("ch0_en_tick", v, 8'hFF);
    sync_tick(); @(negedge clk);
    rd(3'd0, 4'd8, v); chk("ch0_run_b0", v, 8'h00);

    // Ch3 LOAD on a tick edge wins over the decrement
    wr(3'd3, 4'd4, 8'h05);
    wr(3'd3, 4'd5, 8'h00);
    wr(3'd3, 4'd0, 8'h13);
    sync_tick();
    wr(3'd3, 4'd0, 8'h13);
    rd(3'd3, 4'd8, v); chk("ch3_load_tick", v, 8'h05);
    sync_tick(); @(negedge clk);
    rd(3'd3, 4'd8, v); chk("ch3_dec", v, 8'h04);

    // Ch3 STAT clear on the expiry edge: set wins
    wr(3'd3, 4'd4, 8'h00);
    wr(3'd3, 4'd0, 8'h1F);
    rd(3'd3, 4'd1, v); chk("ch3_stat_pre", v, 8'h32);
    sync_tick();
    wr(3'd3, 4'd1, 8'h01);
    rd(3'd3, 4'd1, v); chk("ch3_set_wins", v, 8'h32 | EXP_B);
    wr(3'd3, 4'd1, 8'h01);
    rd(3'd3, 4'd1, v); chk("ch3_clr", v, 8'h32);
    sync_tick(); @(negedge clk);
    chk("ch3_irq", {7'd0, irq}, {7'd0, IRQ_EXP});

    // Asynchronous reset mid-count
    rd(3'd0, 4'd9, v); chk("pre_rst_b1", v, 8'h01);
    sync_tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dato", dato, 8'h00);
    chk("arst_tick", {7'd0, tick_o}, 8'h00);
    chk("arst_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd0, 4'd8, v); chk("post_rst_cnt", v, 8'h00);
    rd(3'd3, 4'd1, v); chk("post_rst_stat", v, 8'h30);
    rd(3'd3, 4'd0, v); chk("post_rst_ctrl", v, 8'h00);
    chk("post_rst_irq", {7'd0, irq}, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel, parametrised successor of the single free-running millisecond timer. It provides CH_NUM independent counters of CTR_W bits, all clocked by one shared tick derived from CLK_HZ/TICK_HZ. Each channel runs either up (free-running) or down (with reload), with atomic multi-byte read latching and an optional expiry interrupt. It sits on the CPU register bus behind a chip-select from the address decoder and is driven by the one-cycle `we_sync`/`oe_sync` strobes.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- TICK_HZ, 1000, shared tick rate; DIV = CLK_HZ/TICK_HZ, integer, ≥2
- CH_NUM, 4, channel count, 1..8
- CTR_W, 16, counter width, one of 8/16/24/32
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- ce  in  1  block select
- addr  in  7  addr[6:4] channel, addr[3:0] register
- dati  in  8  write data
- we  in  1  one-cycle write strobe (cpu.we_sync)
- oe  in  1  one-cycle read strobe (cpu.oe_sync)
- dato  out  8  registered read data
- tick_o  out  1  one-cycle pulse per shared tick
- irq  out  1  OR of enabled channel expiry flags

## Operation
- Tick generator: the divider counts 0..DIV-1. tick_o is asserted during the cycle the divider equals DIV-1, then the divider returns to 0.
- Per-channel registers (byte offsets):
  - 0 CTRL: [0] EN, [1] DOWN, [2] PERIODIC, [3] IE, [4] LOAD (write-only, self-clearing).
  - 1 STAT: [0] EXP, [1] EN, [7:4] = CH_NUM-1. Writing 1 to bit 0 clears EXP.
  - 4..7 RELOAD bytes, LSB first. Bytes at or above CTR_W/8 read 0 and ignore writes.
  - 8..11 COUNT bytes, read-only.
  - Every other offset reads 0xFF.
- Channels with index ≥ CH_NUM read 0xFF and ignore writes.
- Up mode (DOWN=0, EN=1): count+1 on each tick and wraps modulo 2^CTR_W. No expiry.
- Down mode (DOWN=1, EN=1), on each tick:
  - count≠0: count−1.
  - count==0: EXP set; if PERIODIC, count←RELOAD, else EN←0 and count stays 0.
- LOAD=1 written to CTRL: count←RELOAD on the next edge. The other CTRL bits from the same write take effect on that same edge.
- Atomic read: an oe to COUNT byte 0 copies the whole count into a per-channel shadow and returns byte 0 of the live value. Bytes 1..3 return the shadow.
- Simultaneous events:
  - LOAD and a tick on the same edge: LOAD wins, and no decrement happens that edge.
  - EXP clear and expiry on the same edge: set wins.
  - A CTRL write with EN and a tick on the same edge: the tick acts on the old EN.
- Reset mid-operation clears all state immediately, with no completion of pending actions.

## Timing
- Reset values:
  - dato=0x00, tick_o=0, irq=0.
  - Divider, counts, shadows, RELOAD, CTRL and EXP all 0.
- Write: the register updates on the clk edge at which we&ce is sampled high. Side effects are visible from the next cycle.
- Read: dato is updated on the edge that samples oe&ce and holds until the next read.
- irq: combinational OR of (EXP&IE) register bits. It rises the cycle after the expiry tick.
- Count update: happens on the edge where tick_o=1, so the first change occurs DIV cycles after reset release.

## Configuration
- TIMER_BANK_IRQ_EN
  - Defined: EXP flags, IE bit and irq are implemented as above.
  - Undefined: no EXP storage; STAT[0] reads 0; IE is ignored and reads 0; irq is tied to 0. Down-count, reload and stop behaviour are unchanged.

## Structure
- Shared package `timer_bank_pkg` holds:
  - register offset localparams;
  - CTRL/STAT bit-index constants;
  - a `TimerCh` struct (ctrl, reload, count, shadow, exp) for per-channel state.
- One sub-module, `tick_gen` (DIV parameter, clk, rst_n, tick output), also reusable by the LED and button filter logic.
- Channels are built with a generate loop in the top module.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), CH_NUM=4, CTR_W=16.
- Release reset, leave everything idle → tick_o pulses on cycles 10, 20, 30. Ch0 COUNT reads 0x0000. irq=0.
- Ch1: RELOAD=0x0003, CTRL=0x1F (EN|DOWN|PERIODIC|IE|LOAD) → count sequence 3,2,1,0, then at the next tick back to 3. EXP=1 and irq=1 the cycle after. Writing STAT=0x01 clears irq.
- Ch2: one-shot, RELOAD=2, CTRL=0x1B → after 3 ticks count=0, STAT=0x31 (EXP=1, EN=0, CH_NUM-1=3), and the count stays 0 over 5 more ticks.
- Ch0 in up mode with count 0x00FF: read byte 0 (returns 0xFF), let a tick pass, then read byte 1 → returns 0x00 (shadow), not 0x01.
- LOAD write on the same edge as a tick with RELOAD=5 → count=5 afterwards, not 4. A STAT clear coinciding with expiry → EXP stays 1.
- Read ch5, offset 0 → 0xFF. Write ch5 → no channel changes. Assert rst_n low mid-count → all outputs go to reset values asynchronously.
